// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART encodings, frame constants and bit-period helper.
// Revision : 1.0
// ============================================================================

package uart_pkg;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

    // Clocks per bit, rounded to nearest; select code n means 2400 * 2^n baud.
    function automatic int unsigned bitClks(input int unsigned clkHz, input logic [1:0] sel);
        int unsigned baud;
        baud = 32'd2400 << sel;
        return (clkHz + (baud / 2)) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Bit-period divider producing a one-cycle tick every BitClks cycles.
// Revision : 1.0
// ============================================================================

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       i_restart,
    input  logic [1:0] i_baudSel,
    output logic       o_bitTick
);

    localparam int unsigned c_CLKS_2400  = bitClks(CLK_HZ, BAUD_2400);
    localparam int unsigned c_CLKS_4800  = bitClks(CLK_HZ, BAUD_4800);
    localparam int unsigned c_CLKS_9600  = bitClks(CLK_HZ, BAUD_9600);
    localparam int unsigned c_CLKS_19200 = bitClks(CLK_HZ, BAUD_19200);
    localparam int          c_CNT_W      = $clog2(c_CLKS_2400);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_lastCnt;

    always_comb begin
        w_lastCnt = c_CNT_W'(c_CLKS_2400 - 1);
        case (i_baudSel)
            BAUD_2400:  w_lastCnt = c_CNT_W'(c_CLKS_2400 - 1);
            BAUD_4800:  w_lastCnt = c_CNT_W'(c_CLKS_4800 - 1);
            BAUD_9600:  w_lastCnt = c_CNT_W'(c_CLKS_9600 - 1);
            BAUD_19200: w_lastCnt = c_CNT_W'(c_CLKS_19200 - 1);
            default:    w_lastCnt = c_CNT_W'(c_CLKS_2400 - 1);
        endcase
    end

    assign o_bitTick = (r_cnt == w_lastCnt);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_cnt <= '0;
        end else if (i_restart || o_bitTick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_unit.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_unit
// Brief    : UART transmitter, 11-bit frame (start, 8 data LSB first, parity, stop).
// Revision : 1.0
// ============================================================================

module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       Send,
    input  logic [7:0] Data,
    input  logic [1:0] ParityType,
    input  logic [1:0] BaudRate,
    output logic       DataTx,
    output logic       Busy,
    output logic       Done
);

    txState_t   r_state;
    txState_t   w_stateNext;
    logic [2:0] r_bitIdx;
    logic [2:0] w_bitIdxNext;
    logic [7:0] r_data;
    logic [1:0] r_baudSel;
    logic       r_parityBit;
    logic       r_dataTx;
    logic       r_busy;
    logic       r_done;
    logic       w_accept;
    logic       w_bitTick;
    logic       w_parity;
    logic       w_dataTxNext;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_baudTick (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .i_restart (w_accept),
        .i_baudSel (r_baudSel),
        .o_bitTick (w_bitTick)
    );

    assign w_accept = (r_state == ST_IDLE) && Send;

    always_comb begin
        w_parity = 1'b1;
        case (ParityType)
            PAR_ODD:  w_parity = ~^Data;
            PAR_EVEN: w_parity = ^Data;
            default:  w_parity = 1'b1;
        endcase
    end

    always_comb begin
        w_stateNext  = r_state;
        w_bitIdxNext = r_bitIdx;
        w_dataTxNext = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (Send) begin
                    w_stateNext = ST_START;
                end
            end
            ST_START: begin
                if (w_bitTick) begin
                    w_stateNext  = ST_DATA;
                    w_bitIdxNext = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bitTick) begin
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = ST_PARITY;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bitTick) begin
                    w_stateNext = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bitTick) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase

        // Line level is decided from the state being entered so DataTx can be a flop.
        case (w_stateNext)
            ST_START:  w_dataTxNext = 1'b0;
            ST_DATA:   w_dataTxNext = r_data[w_bitIdxNext];
            ST_PARITY: w_dataTxNext = r_parityBit;
            default:   w_dataTxNext = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state     <= ST_IDLE;
            r_bitIdx    <= 3'd0;
            r_data      <= 8'h00;
            r_baudSel   <= 2'b00;
            r_parityBit <= 1'b0;
            r_dataTx    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_bitIdx <= w_bitIdxNext;
            r_dataTx <= w_dataTxNext;
            r_busy   <= (w_stateNext != ST_IDLE);
            r_done   <= (r_state == ST_STOP) && w_bitTick;
            if (w_accept) begin
                r_data      <= Data;
                r_baudSel   <= BaudRate;
                r_parityBit <= w_parity;
            end
        end
    end

    assign DataTx = r_dataTx;
    assign Busy   = r_busy;
    assign Done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_unit
// Brief    : Directed scoreboard bench for uart_tx_unit at CLK_HZ=192000.
// Revision : 1.0
// ============================================================================

module tb_uart_tx_unit;
    import uart_pkg::*;

    typedef struct {
        logic [10:0] bits;
        int          bc;
    } frame_t;

    logic       clk;
    logic       ResetN;
    logic       Send;
    logic [7:0] Data;
    logic [1:0] ParityType;
    logic [1:0] BaudRate;
    logic       DataTx;
    logic       Busy;
    logic       Done;

    frame_t      sbQ[$];
    int          cmpCnt  = 0;
    int          errCnt  = 0;
    int          doneCnt = 0;
    logic [10:0] rxBits  = '0;
    logic [7:0]  rxByte  = '0;

    uart_tx_unit #(
        .CLK_HZ (192_000)
    ) dut (
        .Clock      (clk),
        .ResetN     (ResetN),
        .Send       (Send),
        .Data       (Data),
        .ParityType (ParityType),
        .BaudRate   (BaudRate),
        .DataTx     (DataTx),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Done === 1'b1) doneCnt <= doneCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] d, input logic [1:0] p);
        logic pb;
        case (p)
            2'b01:   pb = ~^d;
            2'b10:   pb = ^d;
            default: pb = 1'b1;
        endcase
        return {1'b1, pb, d, 1'b0};
    endfunction

    task automatic pushFrame(input logic [10:0] bits, input int bc);
        frame_t f;
        f.bits = bits;
        f.bc   = bc;
        sbQ.push_back(f);
    endtask

    task automatic driveSend(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b);
        @(negedge clk);
        Data = d; ParityType = p; BaudRate = b; Send = 1'b1;
        @(negedge clk);
        Send = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int maxCyc);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < maxCyc; n++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Frame monitor: each Busy rise consumes one expected frame and checks it cycle by cycle.
    initial begin : monitor
        frame_t f;
        logic   ok;
        logic   aborted;
        forever begin
            @(negedge clk);
            if (ResetN === 1'b1 && Busy === 1'b1) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_frame", 32'd0, 32'd1);
                    for (int n = 0; n < 2000 && Busy === 1'b1; n++) @(negedge clk);
                end else begin
                    f = sbQ.pop_front();
                    aborted = 1'b0;
                    for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                        ok = 1'b1;
                        for (int c = 0; c < f.bc; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (ResetN !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (DataTx !== f.bits[b] || Busy !== 1'b1 || Done !== 1'b0) ok = 1'b0;
                            if (c == f.bc / 2) rxBits[b] = DataTx;
                        end
                        if (!aborted) check($sformatf("frame_bit%0d", b), 32'(ok), 32'd1);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check("done_cycle", 32'({Busy, Done, DataTx}), 32'b011);
                        rxByte = rxBits[8:1];
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int doneBefore;
        ResetN = 1'b0; Send = 1'b0; Data = 8'h00; ParityType = 2'b00; BaudRate = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_tx",   32'(DataTx), 32'd1);
        check("rst_busy", 32'(Busy),   32'd0);
        check("rst_done", 32'(Done),   32'd0);
        ResetN = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx", 32'(DataTx), 32'd1);

        // 1: A5, even parity, 19200 baud; inputs change after accept
        pushFrame(11'b10101001010, 10);
        driveSend(8'hA5, 2'b10, 2'b11);
        Data = 8'h00; ParityType = 2'b01; BaudRate = 2'b00;
        waitDone("t1_done", 200);

        // 2: 00, odd parity, 2400 baud
        pushFrame(makeFrame(8'h00, 2'b01), 80);
        driveSend(8'h00, 2'b01, 2'b00);
        waitDone("t2_done", 1000);

        // 3: 3C, parity none (11), decoded by mid-bit sampling
        pushFrame(makeFrame(8'h3C, 2'b11), 10);
        driveSend(8'h3C, 2'b11, 2'b11);
        waitDone("t3_done", 200);
        @(negedge clk);
        check("t3_rx_byte", 32'(rxByte),    32'h3C);
        check("t3_par",     32'(rxBits[9]), 32'd1);
        check("t3_stop",    32'(rxBits[10]), 32'd1);

        // 4: Send held high, 55 then AA back-to-back
        pushFrame(makeFrame(8'h55, 2'b10), 10);
        @(negedge clk);
        Data = 8'h55; ParityType = 2'b10; BaudRate = 2'b11; Send = 1'b1;
        @(negedge clk);
        Data = 8'hAA;
        pushFrame(makeFrame(8'hAA, 2'b10), 10);
        waitDone("t4_done1", 200);
        @(negedge clk);
        check("t4_gap_busy", 32'(Busy),   32'd1);
        check("t4_gap_tx",   32'(DataTx), 32'd0);
        Send = 1'b0;
        waitDone("t4_done2", 200);

        // 5: Send and Data change mid-frame are ignored
        repeat (3) @(negedge clk);
        doneBefore = doneCnt;
        pushFrame(makeFrame(8'hC3, 2'b01), 10);
        driveSend(8'hC3, 2'b01, 2'b11);
        repeat (40) @(negedge clk);
        Data = 8'hFF; ParityType = 2'b10; Send = 1'b1;
        @(negedge clk);
        Send = 1'b0;
        waitDone("t5_done", 200);
        repeat (20) @(negedge clk);
        check("t5_done_once", 32'(doneCnt - doneBefore), 32'd1);
        check("t5_idle",      32'(Busy), 32'd0);

        // 6: reset during data bit 4
        pushFrame(makeFrame(8'h96, 2'b10), 10);
        driveSend(8'h96, 2'b10, 2'b11);
        repeat (53) @(negedge clk);
        doneBefore = doneCnt;
        #2 ResetN = 1'b0;
        #1;
        check("t6_rst_tx",   32'(DataTx), 32'd1);
        check("t6_rst_busy", 32'(Busy),   32'd0);
        repeat (3) @(negedge clk);
        ResetN = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_done", 32'(doneCnt - doneBefore), 32'd0);
        pushFrame(makeFrame(8'h5A, 2'b01), 10);
        driveSend(8'h5A, 2'b01, 2'b11);
        waitDone("t6_done", 200);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

`default_nettype wire
